// File: rtl/sensor_init_seq.sv
// sensor_init_seq: walks an external register table (addr, data, post-write wait)
// and writes each entry over a level-request / done-pulse handshake, with per-entry
// retry on NACK or watchdog expiry and a programmable delay after each write.
// Latency: init_req at edge N -> wr_req after N+1; last wr_done (wait=0) at M -> init_done after M+1.
module sensor_init_seq #(
  parameter int DEPTH     = 5,     // table entries, 1..64
  parameter int AW        = 8,     // register address width
  parameter int DW        = 8,     // register data width
  parameter int WW        = 16,    // post-write wait width
  parameter int MAX_RETRY = 3,     // retries allowed per entry
  parameter int TIMEOUT   = 4095   // wr_done watchdog, cycles
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   init_req,
  output logic [5:0]             tbl_idx,
  input  logic [AW+DW+WW-1:0]    tbl_entry,
  output logic                   wr_req,
  output logic [AW-1:0]          wr_addr,
  output logic [DW-1:0]          wr_data,
  input  logic                   wr_done,
  input  logic                   wr_err,
  output logic                   busy,
  output logic                   init_done,
  output logic                   init_fail,
  output logic [5:0]             fail_idx
);

  // Counter widths: retry counter holds 0..MAX_RETRY, watchdog holds 0..TIMEOUT-1.
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_ACK,
    S_DELAY,
    S_NEXT,
    S_DONE,
    S_FAIL
  } state_t;

  state_t          state_q;
  logic [5:0]      idx_q;
  logic [RW-1:0]   retry_q;
  logic [TW-1:0]   wdog_q;
  logic [WW-1:0]   wait_q;
  logic            wr_req_q;
  logic [AW-1:0]   wr_addr_q;
  logic [DW-1:0]   wr_data_q;
  logic            busy_q;
  logic            init_done_q;
  logic            init_fail_q;
  logic [5:0]      fail_idx_q;

  // Fields of the entry currently addressed by tbl_idx; captured in ISSUE.
  logic [AW-1:0]   tbl_addr_d;
  logic [DW-1:0]   tbl_data_d;
  logic [WW-1:0]   tbl_wait_d;

  logic            ack_ok;
  logic            ack_bad;
  logic            wdog_hit;
  logic            retry_left;
  logic            last_entry;

  assign {tbl_addr_d, tbl_data_d, tbl_wait_d} = tbl_entry;

  // Handshake outcome and bookkeeping conditions evaluated in WAIT_ACK / NEXT.
  assign ack_ok     = wr_done & ~wr_err;
  assign ack_bad    = wr_done &  wr_err;
  assign wdog_hit   = (wdog_q == TW'(TIMEOUT - 1));
  assign retry_left = (retry_q < RW'(MAX_RETRY));
  assign last_entry = (idx_q == 6'(DEPTH - 1));

  // Sequencer: all outputs are registered and updated on the transition into each state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      retry_q     <= '0;
      wdog_q      <= '0;
      wait_q      <= '0;
      wr_req_q    <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      busy_q      <= 1'b0;
      init_done_q <= 1'b0;
      init_fail_q <= 1'b0;
      fail_idx_q  <= '0;
    end else begin
      case (state_q)
        // Quiescent states: only init_req does anything here.
        S_IDLE, S_DONE, S_FAIL: begin
          if (init_req) begin
            init_done_q <= 1'b0;
            init_fail_q <= 1'b0;
            retry_q     <= '0;
            idx_q       <= '0;
            busy_q      <= 1'b1;
            state_q     <= S_ISSUE;
          end
        end

        // Capture the table entry so the bus stays stable for the whole request.
        S_ISSUE: begin
          wr_addr_q <= tbl_addr_d;
          wr_data_q <= tbl_data_d;
          wait_q    <= tbl_wait_d;
          wdog_q    <= '0;
          wr_req_q  <= 1'b1;
          state_q   <= S_WAIT_ACK;
        end

        // Request outstanding: success, NACK or watchdog expiry.
        S_WAIT_ACK: begin
          if (ack_ok) begin
            wr_req_q <= 1'b0;
            if (wait_q != '0) begin
              state_q <= S_DELAY;
            end else begin
              state_q <= S_NEXT;
            end
          end else if (ack_bad || wdog_hit) begin
            wr_req_q <= 1'b0;
            if (retry_left) begin
              retry_q <= retry_q + 1'b1;
              state_q <= S_ISSUE;
            end else begin
              fail_idx_q  <= idx_q;
              init_fail_q <= 1'b1;
              busy_q      <= 1'b0;
              state_q     <= S_FAIL;
            end
          end else begin
            wdog_q <= wdog_q + 1'b1;
          end
        end

        // wait_q counts down so DELAY occupies exactly the programmed cycles.
        S_DELAY: begin
          if (wait_q == WW'(1)) begin
            state_q <= S_NEXT;
          end
          wait_q <= wait_q - 1'b1;
        end

        // Advance to the next entry or finish the table.
        S_NEXT: begin
          if (last_entry) begin
            init_done_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= S_DONE;
          end else begin
            idx_q   <= idx_q + 6'd1;
            retry_q <= '0;
            state_q <= S_ISSUE;
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign tbl_idx   = idx_q;
  assign wr_req    = wr_req_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign busy      = busy_q;
  assign init_done = init_done_q;
  assign init_fail = init_fail_q;
  assign fail_idx  = fail_idx_q;

endmodule

// File: tb/tb_sensor_init_seq.sv
// Bench for sensor_init_seq: a register-write responder (ACK 3 cycles after wr_req,
// optional NACKs), an event monitor, and one task per scenario.
module tb_sensor_init_seq;

  localparam int AW = 8;
  localparam int DW = 8;
  localparam int WW = 16;
  localparam int EW = AW + DW + WW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          init_req, init_req2;
  logic [5:0]    tbl_idx, tbl_idx2, fail_idx, fail_idx2;
  logic [EW-1:0] tbl_entry, tbl_entry2;
  logic          wr_req, wr_req2;
  logic [AW-1:0] wr_addr, wr_addr2;
  logic [DW-1:0] wr_data, wr_data2;
  logic          wr_done = 1'b0;
  logic          wr_err  = 1'b0;
  logic          wr_done2, wr_err2;
  logic          busy, busy2, init_done, init_done2, init_fail, init_fail2;

  assign wr_done2 = 1'b0;
  assign wr_err2  = 1'b0;

  function automatic logic [EW-1:0] tbl_rom(input logic [5:0] i);
    case (i)
      6'd0:    tbl_rom = {8'h6B, 8'h00, 16'd100};
      6'd1:    tbl_rom = {8'h19, 8'h29, 16'd0};
      6'd2:    tbl_rom = {8'h1A, 8'h03, 16'd0};
      6'd3:    tbl_rom = {8'h1B, 8'h18, 16'd0};
      6'd4:    tbl_rom = {8'h1C, 8'h10, 16'd0};
      default: tbl_rom = '0;
    endcase
  endfunction

  assign tbl_entry  = tbl_rom(tbl_idx);
  assign tbl_entry2 = tbl_rom(tbl_idx2);

  sensor_init_seq dut (
    .clk(clk), .rst(rst), .init_req(init_req), .tbl_idx(tbl_idx), .tbl_entry(tbl_entry),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_done(wr_done), .wr_err(wr_err),
    .busy(busy), .init_done(init_done), .init_fail(init_fail), .fail_idx(fail_idx)
  );

  sensor_init_seq #(.TIMEOUT(15)) dut_to (
    .clk(clk), .rst(rst), .init_req(init_req2), .tbl_idx(tbl_idx2), .tbl_entry(tbl_entry2),
    .wr_req(wr_req2), .wr_addr(wr_addr2), .wr_data(wr_data2), .wr_done(wr_done2), .wr_err(wr_err2),
    .busy(busy2), .init_done(init_done2), .init_fail(init_fail2), .fail_idx(fail_idx2)
  );

  logic [7:0] exp_addr [0:4] = '{8'h6B, 8'h19, 8'h1A, 8'h1B, 8'h1C};
  logic [7:0] exp_data [0:4] = '{8'h00, 8'h29, 8'h03, 8'h18, 8'h10};

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor state (written only by the negedge process below)
  int         rise_q[$];
  int         ack_q[$];
  int         done_q[$];
  int         hold2_q[$];
  logic [7:0] log_addr[$];
  logic [7:0] log_data[$];
  int         att[256];
  int         stab_err = 0;
  int         hcnt2 = 0;
  int         rcnt = 0;
  int         seen_gen = 0;
  int         nack_cnt = 0;
  int         spur_ack = 0;
  bit         real_ack = 1'b0;
  logic       prev_req = 1'b0, prev_req2 = 1'b0, prev_done = 1'b0;
  logic [7:0] prev_addr = '0, prev_data = '0;

  // Stimulus knobs (written only by the test tasks)
  logic [7:0] nack_addr = 8'hFF;
  int         nack_n    = 0;
  int         nack_gen  = 0;
  int         spur_req  = 0;

  // Observe what the DUT did at the preceding rising edge, then act as the write slave.
  always @(negedge clk) begin
    if (wr_done && real_ack) ack_q.push_back(cyc);
    if (wr_req && !prev_req) rise_q.push_back(cyc);
    if (wr_req && prev_req && (wr_addr !== prev_addr || wr_data !== prev_data)) stab_err++;
    if (wr_req2) hcnt2++;
    else begin
      if (prev_req2) hold2_q.push_back(hcnt2);
      hcnt2 = 0;
    end
    if (init_done && !prev_done) done_q.push_back(cyc);
    prev_req  = wr_req;
    prev_req2 = wr_req2;
    prev_done = init_done;
    prev_addr = wr_addr;
    prev_data = wr_data;

    if (nack_gen != seen_gen) begin
      seen_gen = nack_gen;
      nack_cnt = 0;
    end
    if (wr_done) begin
      wr_done  = 1'b0;
      wr_err   = 1'b0;
      real_ack = 1'b0;
      rcnt     = 0;
    end else if (wr_req) begin
      rcnt++;
      if (rcnt == 3) begin
        wr_done  = 1'b1;
        real_ack = 1'b1;
        wr_err   = (wr_addr == nack_addr) && (nack_cnt < nack_n);
        if (wr_err) nack_cnt++;
        att[wr_addr]++;
        log_addr.push_back(wr_addr);
        log_data.push_back(wr_data);
      end
    end else begin
      rcnt = 0;
      if (spur_req != spur_ack) begin
        spur_ack = spur_req;
        wr_done  = 1'b1;
        real_ack = 1'b0;
      end
    end
  end

  // Drive a one-cycle init_req; it is sampled at edge drv_cyc+1.
  task automatic pulse_init(output int drv_cyc);
    @(negedge clk); #1;
    init_req = 1'b1;
    drv_cyc  = cyc;
    @(negedge clk); #1;
    init_req = 1'b0;
  endtask

  task automatic test_reset();
    init_req = 1'b0; init_req2 = 1'b0;
    rst = 1'b1; #1; rst = 1'b0;
    repeat (3) @(negedge clk); #1;
    n_cmp++; if (wr_req    !== 1'b0) begin n_bad++; $display("FAIL rst_wr_req got %b want 0", wr_req); end
    n_cmp++; if (busy      !== 1'b0) begin n_bad++; $display("FAIL rst_busy got %b want 0", busy); end
    n_cmp++; if (init_done !== 1'b0) begin n_bad++; $display("FAIL rst_init_done got %b want 0", init_done); end
    n_cmp++; if (init_fail !== 1'b0) begin n_bad++; $display("FAIL rst_init_fail got %b want 0", init_fail); end
    n_cmp++; if (fail_idx  !== 6'd0) begin n_bad++; $display("FAIL rst_fail_idx got %0d want 0", fail_idx); end
    n_cmp++; if (tbl_idx   !== 6'd0) begin n_bad++; $display("FAIL rst_tbl_idx got %0d want 0", tbl_idx); end
    n_cmp++; if (wr_addr   !== 8'h00) begin n_bad++; $display("FAIL rst_wr_addr got %0h want 0", wr_addr); end
    n_cmp++; if (wr_data   !== 8'h00) begin n_bad++; $display("FAIL rst_wr_data got %0h want 0", wr_data); end
    n_cmp++; if (busy2     !== 1'b0) begin n_bad++; $display("FAIL rst_busy2 got %b want 0", busy2); end
    rst = 1'b1;
    repeat (5) @(negedge clk); #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL idle_no_start busy got %b want 0", busy); end
  endtask

  task automatic test_nominal();
    int b_r, b_a, b_l, b_d, s0, n0;
    b_r = rise_q.size(); b_a = ack_q.size(); b_l = log_addr.size(); b_d = done_q.size(); s0 = stab_err;
    pulse_init(n0);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL nom_busy got %b want 1", busy); end
    for (int k = 0; k < 1000 && !init_done; k++) @(negedge clk);
    #1;
    n_cmp++; if (init_done !== 1'b1) begin n_bad++; $display("FAIL nom_done got %b want 1", init_done); end
    n_cmp++; if (log_addr.size() - b_l !== 5) begin n_bad++; $display("FAIL nom_writes got %0d want 5", log_addr.size() - b_l); end
    for (int i = 0; i < 5; i++) begin
      if (b_l + i < log_addr.size()) begin
        n_cmp++;
        if (log_addr[b_l+i] !== exp_addr[i] || log_data[b_l+i] !== exp_data[i]) begin
          n_bad++;
          $display("FAIL nom_write%0d got %0h/%0h want %0h/%0h", i, log_addr[b_l+i], log_data[b_l+i], exp_addr[i], exp_data[i]);
        end
      end
    end
    if (rise_q.size() < b_r + 3 || ack_q.size() < b_a + 5 || done_q.size() < b_d + 1) begin
      n_cmp++; n_bad++;
      $display("FAIL nom_events got rises=%0d acks=%0d dones=%0d want >=3/5/1", rise_q.size() - b_r, ack_q.size() - b_a, done_q.size() - b_d);
    end else begin
      n_cmp++; if (rise_q[b_r] - n0 !== 2) begin n_bad++; $display("FAIL nom_req_latency got %0d want 2", rise_q[b_r] - n0); end
      n_cmp++; if (rise_q[b_r+1] - ack_q[b_a] !== 102) begin n_bad++; $display("FAIL nom_delay_gap got %0d want 102", rise_q[b_r+1] - ack_q[b_a]); end
      n_cmp++; if (rise_q[b_r+2] - ack_q[b_a+1] !== 2) begin n_bad++; $display("FAIL nom_nodelay_gap got %0d want 2", rise_q[b_r+2] - ack_q[b_a+1]); end
      n_cmp++; if (done_q[b_d] - ack_q[b_a+4] !== 1) begin n_bad++; $display("FAIL nom_done_latency got %0d want 1", done_q[b_d] - ack_q[b_a+4]); end
    end
    n_cmp++; if (init_fail !== 1'b0) begin n_bad++; $display("FAIL nom_fail got %b want 0", init_fail); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL nom_busy_end got %b want 0", busy); end
    n_cmp++; if (stab_err !== s0) begin n_bad++; $display("FAIL nom_bus_stable got %0d changes want 0", stab_err - s0); end
  endtask

  task automatic test_retry();
    int a2, a4, b_l, n0;
    nack_addr = 8'h1A; nack_n = 2; nack_gen++;
    a2 = att[8'h1A]; a4 = att[8'h1C]; b_l = log_addr.size();
    pulse_init(n0);
    for (int k = 0; k < 1000 && !init_done && !init_fail; k++) @(negedge clk);
    #1;
    n_cmp++; if (att[8'h1A] - a2 !== 3) begin n_bad++; $display("FAIL retry_attempts got %0d want 3", att[8'h1A] - a2); end
    n_cmp++; if (att[8'h1C] - a4 !== 1) begin n_bad++; $display("FAIL retry_last_entry got %0d want 1", att[8'h1C] - a4); end
    n_cmp++; if (log_addr.size() - b_l !== 7) begin n_bad++; $display("FAIL retry_writes got %0d want 7", log_addr.size() - b_l); end
    n_cmp++; if (init_done !== 1'b1) begin n_bad++; $display("FAIL retry_done got %b want 1", init_done); end
    n_cmp++; if (init_fail !== 1'b0) begin n_bad++; $display("FAIL retry_fail got %b want 0", init_fail); end
    nack_n = 0; nack_gen++;
  endtask

  task automatic test_fail();
    int a3, a4, b_r, n0;
    nack_addr = 8'h1B; nack_n = 4; nack_gen++;
    a3 = att[8'h1B]; a4 = att[8'h1C];
    pulse_init(n0);
    for (int k = 0; k < 1000 && !init_fail && !init_done; k++) @(negedge clk);
    #1;
    n_cmp++; if (init_fail !== 1'b1) begin n_bad++; $display("FAIL fail_flag got %b want 1", init_fail); end
    n_cmp++; if (fail_idx !== 6'd3) begin n_bad++; $display("FAIL fail_idx got %0d want 3", fail_idx); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL fail_busy got %b want 0", busy); end
    n_cmp++; if (init_done !== 1'b0) begin n_bad++; $display("FAIL fail_done got %b want 0", init_done); end
    n_cmp++; if (att[8'h1B] - a3 !== 4) begin n_bad++; $display("FAIL fail_attempts got %0d want 4", att[8'h1B] - a3); end
    b_r = rise_q.size();
    repeat (10) @(negedge clk); #1;
    n_cmp++; if (att[8'h1C] - a4 !== 0) begin n_bad++; $display("FAIL fail_no_1c got %0d want 0", att[8'h1C] - a4); end
    n_cmp++; if (rise_q.size() !== b_r) begin n_bad++; $display("FAIL fail_quiet got %0d new requests want 0", rise_q.size() - b_r); end
    n_cmp++; if (init_fail !== 1'b1) begin n_bad++; $display("FAIL fail_sticky got %b want 1", init_fail); end
    nack_n = 0; nack_gen++;
  endtask

  task automatic test_timeout();
    int b;
    b = hold2_q.size();
    @(negedge clk); #1; init_req2 = 1'b1;
    @(negedge clk); #1; init_req2 = 1'b0;
    for (int k = 0; k < 300 && !init_fail2; k++) @(negedge clk);
    #1;
    n_cmp++; if (hold2_q.size() - b !== 4) begin n_bad++; $display("FAIL to_attempts got %0d want 4", hold2_q.size() - b); end
    for (int i = b; i < hold2_q.size(); i++) begin
      n_cmp++; if (hold2_q[i] !== 15) begin n_bad++; $display("FAIL to_hold%0d got %0d want 15", i - b, hold2_q[i]); end
    end
    n_cmp++; if (init_fail2 !== 1'b1) begin n_bad++; $display("FAIL to_fail got %b want 1", init_fail2); end
    n_cmp++; if (fail_idx2 !== 6'd0) begin n_bad++; $display("FAIL to_fail_idx got %0d want 0", fail_idx2); end
    n_cmp++; if (busy2 !== 1'b0) begin n_bad++; $display("FAIL to_busy got %b want 0", busy2); end
  endtask

  task automatic test_reset_midop();
    int b_a, b_r, n0;
    b_a = ack_q.size();
    pulse_init(n0);
    for (int k = 0; k < 100 && ack_q.size() == b_a; k++) begin @(negedge clk); #1; end
    repeat (10) @(negedge clk); #1;
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL rmid_busy_before got %b want 1", busy); end
    rst = 1'b0; #1;
    n_cmp++; if (wr_req !== 1'b0) begin n_bad++; $display("FAIL rmid_wr_req got %b want 0", wr_req); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rmid_busy got %b want 0", busy); end
    n_cmp++; if (tbl_idx !== 6'd0) begin n_bad++; $display("FAIL rmid_tbl_idx got %0d want 0", tbl_idx); end
    b_r = rise_q.size();
    repeat (3) @(negedge clk); #1; rst = 1'b1;
    repeat (20) @(negedge clk); #1;
    n_cmp++; if (rise_q.size() !== b_r) begin n_bad++; $display("FAIL rmid_idle got %0d requests want 0", rise_q.size() - b_r); end
    pulse_init(n0);
    for (int k = 0; k < 20 && rise_q.size() == b_r; k++) begin @(negedge clk); #1; end
    n_cmp++; if (wr_addr !== 8'h6B) begin n_bad++; $display("FAIL rmid_restart_addr got %0h want 6b", wr_addr); end
    n_cmp++; if (tbl_idx !== 6'd0) begin n_bad++; $display("FAIL rmid_restart_idx got %0d want 0", tbl_idx); end
    // Second abort: while the write to entry 1 is outstanding.
    for (int k = 0; k < 200 && rise_q.size() < b_r + 2; k++) begin @(negedge clk); #1; end
    n_cmp++; if (wr_req !== 1'b1 || tbl_idx !== 6'd1) begin n_bad++; $display("FAIL rmid_e1_req got %b/%0d want 1/1", wr_req, tbl_idx); end
    rst = 1'b0; #1;
    n_cmp++; if (wr_req !== 1'b0 || tbl_idx !== 6'd0) begin n_bad++; $display("FAIL rmid_e1_abort got %b/%0d want 0/0", wr_req, tbl_idx); end
    repeat (2) @(negedge clk); #1; rst = 1'b1;
    repeat (3) @(negedge clk); #1;
  endtask

  task automatic test_spurious();
    int b_l, b_r, b_a, n0;
    b_l = log_addr.size(); b_r = rise_q.size(); b_a = ack_q.size();
    pulse_init(n0);
    for (int k = 0; k < 100 && ack_q.size() == b_a; k++) begin @(negedge clk); #1; end
    repeat (5) @(negedge clk); #1;
    spur_req++;
    init_req = 1'b1;
    @(negedge clk); #1; init_req = 1'b0;
    for (int k = 0; k < 1000 && !init_done; k++) @(negedge clk);
    #1;
    n_cmp++; if (init_done !== 1'b1) begin n_bad++; $display("FAIL spur_done got %b want 1", init_done); end
    n_cmp++; if (rise_q.size() - b_r !== 5) begin n_bad++; $display("FAIL spur_requests got %0d want 5", rise_q.size() - b_r); end
    for (int i = 0; i < 5; i++) begin
      if (b_l + i < log_addr.size()) begin
        n_cmp++; if (log_addr[b_l+i] !== exp_addr[i]) begin n_bad++; $display("FAIL spur_order%0d got %0h want %0h", i, log_addr[b_l+i], exp_addr[i]); end
      end
    end
    if (rise_q.size() > b_r + 1 && ack_q.size() > b_a) begin
      n_cmp++; if (rise_q[b_r+1] - ack_q[b_a] !== 102) begin n_bad++; $display("FAIL spur_delay_gap got %0d want 102", rise_q[b_r+1] - ack_q[b_a]); end
    end
    // Stray wr_done while DONE, then a rerun of the whole table.
    spur_req++;
    repeat (5) @(negedge clk); #1;
    n_cmp++; if (init_done !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL spur_idle got done=%b busy=%b want 1/0", init_done, busy); end
    b_l = log_addr.size();
    pulse_init(n0);
    n_cmp++; if (init_done !== 1'b0) begin n_bad++; $display("FAIL rerun_clear got %b want 0", init_done); end
    for (int k = 0; k < 1000 && !init_done; k++) @(negedge clk);
    #1;
    n_cmp++; if (log_addr.size() - b_l !== 5) begin n_bad++; $display("FAIL rerun_writes got %0d want 5", log_addr.size() - b_l); end
    n_cmp++; if (init_done !== 1'b1) begin n_bad++; $display("FAIL rerun_done got %b want 1", init_done); end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_retry();
    test_fail();
    test_timeout();
    test_reset_midop();
    test_spurious();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout simulation did not complete, got stuck want finish");
    $fatal(1);
  end

endmodule
